// File: rtl/vga_framebuffer_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port frame buffer memory:
// pxl has priority, pro is guarded against starvation, reads are routed back in order.
module vga_framebuffer_arbiter #(
  parameter int AVN_AW         = 18,
  parameter int AVN_DW         = 16,
  parameter int MAX_OUTST      = 4,
  parameter int PXL_MAX_CONSEC = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pro_avn_read,
  input  logic                pro_avn_write,
  input  logic [AVN_AW-1:0]   pro_avn_address,
  input  logic [AVN_DW-1:0]   pro_avn_writedata,
  input  logic [AVN_DW/8-1:0] pro_avn_byteenable,
  output logic [AVN_DW-1:0]   pro_avn_readdata,
  output logic                pro_avn_readdatavalid,
  output logic                pro_avn_waitrequest,
  input  logic                pxl_avn_read,
  input  logic                pxl_avn_write,
  input  logic [AVN_AW-1:0]   pxl_avn_address,
  input  logic [AVN_DW-1:0]   pxl_avn_writedata,
  input  logic [AVN_DW/8-1:0] pxl_avn_byteenable,
  output logic [AVN_DW-1:0]   pxl_avn_readdata,
  output logic                pxl_avn_readdatavalid,
  output logic                pxl_avn_waitrequest,
  output logic                mem_avn_read,
  output logic                mem_avn_write,
  output logic [AVN_AW-1:0]   mem_avn_address,
  output logic [AVN_DW-1:0]   mem_avn_writedata,
  output logic [AVN_DW/8-1:0] mem_avn_byteenable,
  input  logic [AVN_DW-1:0]   mem_avn_readdata,
  input  logic                mem_avn_readdatavalid,
  input  logic                mem_avn_waitrequest,
  output logic                err_rdv_unexp
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(PXL_MAX_CONSEC + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
  localparam logic [SW-1:0] MAX_STV = SW'(PXL_MAX_CONSEC);
  localparam logic ID_PRO = 1'b0;
  localparam logic ID_PXL = 1'b1;

  logic                 lock_q, lock_d, lock_id_q, lock_id_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [MAX_OUTST-1:0] id_fifo_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q;

  // A port driving read and write together is treated as writing.
  logic pro_wr, pro_rd, pxl_wr, pxl_rd, room, pro_elig, pxl_elig;
  assign pro_wr   = pro_avn_write;
  assign pro_rd   = pro_avn_read & ~pro_avn_write;
  assign pxl_wr   = pxl_avn_write;
  assign pxl_rd   = pxl_avn_read & ~pxl_avn_write;
  assign room     = cnt_q < MAX_CNT;
  assign pro_elig = pro_wr | (pro_rd & room);
  assign pxl_elig = pxl_wr | (pxl_rd & room);

  logic gnt_vld, gnt_id;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ID_PRO;
    if (sys_rst) begin
      gnt_vld = 1'b0;
    end else if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (pxl_elig && (starve_q < MAX_STV || !pro_elig)) begin
      gnt_vld = 1'b1;
      gnt_id  = ID_PXL;
    end else if (pro_elig) begin
      gnt_vld = 1'b1;
      gnt_id  = ID_PRO;
    end
  end

  always_comb begin
    mem_avn_read       = 1'b0;
    mem_avn_write      = 1'b0;
    mem_avn_address    = '0;
    mem_avn_writedata  = '0;
    mem_avn_byteenable = '0;
    if (gnt_vld) begin
      if (gnt_id == ID_PXL) begin
        mem_avn_read       = pxl_rd;
        mem_avn_write      = pxl_wr;
        mem_avn_address    = pxl_avn_address;
        mem_avn_writedata  = pxl_avn_writedata;
        mem_avn_byteenable = pxl_avn_byteenable;
      end else begin
        mem_avn_read       = pro_rd;
        mem_avn_write      = pro_wr;
        mem_avn_address    = pro_avn_address;
        mem_avn_writedata  = pro_avn_writedata;
        mem_avn_byteenable = pro_avn_byteenable;
      end
    end
  end

  logic mem_req, mem_fire, push, pop, head;
  assign mem_req  = mem_avn_read | mem_avn_write;
  assign mem_fire = mem_req & ~mem_avn_waitrequest;
  assign push     = mem_fire & mem_avn_read;
  assign pop      = mem_avn_readdatavalid & (cnt_q != '0) & ~sys_rst;
  assign head     = id_fifo_q[rd_ptr_q];

  assign pro_avn_waitrequest   = ~(gnt_vld & (gnt_id == ID_PRO)) | mem_avn_waitrequest;
  assign pxl_avn_waitrequest   = ~(gnt_vld & (gnt_id == ID_PXL)) | mem_avn_waitrequest;
  assign pro_avn_readdata      = mem_avn_readdata;
  assign pxl_avn_readdata      = mem_avn_readdata;
  assign pro_avn_readdatavalid = pop & (head == ID_PRO);
  assign pxl_avn_readdatavalid = pop & (head == ID_PXL);
  assign err_rdv_unexp         = err_q;

  // A stalled request pins the grant until the memory accepts it.
  always_comb begin
    lock_d    = mem_req & mem_avn_waitrequest;
    lock_id_d = lock_d ? gnt_id : lock_id_q;
    starve_d  = starve_q;
    if (!(pro_avn_read | pro_avn_write))
      starve_d = '0;
    else if (mem_fire && gnt_id == ID_PRO)
      starve_d = '0;
    else if (mem_fire && gnt_id == ID_PXL && starve_q != MAX_STV)
      starve_d = starve_q + 1'b1;
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !push)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_PRO;
      starve_q  <= '0;
      id_fifo_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      starve_q  <= starve_d;
      cnt_q     <= cnt_d;
      if (push) begin
        id_fifo_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (mem_avn_readdatavalid && cnt_q == '0)
        err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Directed bench for vga_framebuffer_arbiter: priority/starvation, hold, outstanding limit,
// unexpected responses and asynchronous reset.
module tb_vga_framebuffer_arbiter;
  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        pro_avn_read, pro_avn_write, pxl_avn_read, pxl_avn_write;
  logic [17:0] pro_avn_address, pxl_avn_address, mem_avn_address;
  logic [15:0] pro_avn_writedata, pxl_avn_writedata, mem_avn_writedata;
  logic [1:0]  pro_avn_byteenable, pxl_avn_byteenable, mem_avn_byteenable;
  logic [15:0] pro_avn_readdata, pxl_avn_readdata, mem_avn_readdata;
  logic        pro_avn_readdatavalid, pro_avn_waitrequest;
  logic        pxl_avn_readdatavalid, pxl_avn_waitrequest;
  logic        mem_avn_read, mem_avn_write, mem_avn_readdatavalid, mem_avn_waitrequest;
  logic        err_rdv_unexp;
  int checks = 0, errors = 0;

  always #5 sys_clk = ~sys_clk;

  vga_framebuffer_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .pro_avn_read(pro_avn_read), .pro_avn_write(pro_avn_write),
    .pro_avn_address(pro_avn_address), .pro_avn_writedata(pro_avn_writedata),
    .pro_avn_byteenable(pro_avn_byteenable), .pro_avn_readdata(pro_avn_readdata),
    .pro_avn_readdatavalid(pro_avn_readdatavalid), .pro_avn_waitrequest(pro_avn_waitrequest),
    .pxl_avn_read(pxl_avn_read), .pxl_avn_write(pxl_avn_write),
    .pxl_avn_address(pxl_avn_address), .pxl_avn_writedata(pxl_avn_writedata),
    .pxl_avn_byteenable(pxl_avn_byteenable), .pxl_avn_readdata(pxl_avn_readdata),
    .pxl_avn_readdatavalid(pxl_avn_readdatavalid), .pxl_avn_waitrequest(pxl_avn_waitrequest),
    .mem_avn_read(mem_avn_read), .mem_avn_write(mem_avn_write),
    .mem_avn_address(mem_avn_address), .mem_avn_writedata(mem_avn_writedata),
    .mem_avn_byteenable(mem_avn_byteenable), .mem_avn_readdata(mem_avn_readdata),
    .mem_avn_readdatavalid(mem_avn_readdatavalid), .mem_avn_waitrequest(mem_avn_waitrequest),
    .err_rdv_unexp(err_rdv_unexp)
  );

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic idle();
    pro_avn_read = 0; pro_avn_write = 0; pro_avn_address = '0;
    pro_avn_writedata = '0; pro_avn_byteenable = 2'b11;
    pxl_avn_read = 0; pxl_avn_write = 0; pxl_avn_address = '0;
    pxl_avn_writedata = '0; pxl_avn_byteenable = 2'b11;
    mem_avn_readdata = '0; mem_avn_readdatavalid = 0; mem_avn_waitrequest = 0;
  endtask

  task automatic test_reset();
    idle();
    pro_avn_read = 1; pxl_avn_read = 1; mem_avn_readdatavalid = 1;
    #2;
    checks++;
    if ({mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest,
         pro_avn_readdatavalid, pxl_avn_readdatavalid, err_rdv_unexp} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0011000",
        {mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest,
         pro_avn_readdatavalid, pxl_avn_readdatavalid, err_rdv_unexp});
    end
    idle();
    tick(); tick();
    sys_rst = 0;
    tick();
  endtask

  // Both ports read back to back; memory answers one cycle after each accept.
  task automatic test_prio_starve();
    logic        prev_vld = 0, prev_pxl = 0, exp_pxl;
    logic [17:0] prev_addr = '0, exp_addr;
    for (int c = 0; c < 18; c++) begin
      pro_avn_read = 1; pxl_avn_read = 1;
      pro_avn_address = 18'h200 + 18'(c);
      pxl_avn_address = 18'h100 + 18'(c);
      mem_avn_readdatavalid = prev_vld;
      mem_avn_readdata = prev_addr[15:0];
      exp_pxl  = (c % 9) != 8;
      exp_addr = exp_pxl ? 18'h100 + 18'(c) : 18'h200 + 18'(c);
      #2;
      checks++;
      if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest, mem_avn_address}
          !== {1'b1, 1'b0, ~exp_pxl, exp_pxl, exp_addr}) begin
        errors++;
        $display("FAIL prio_grant c=%0d: got rd=%b wr=%b pxl_wait=%b pro_wait=%b addr=%h required pxl_win=%b addr=%h",
          c, mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest,
          mem_avn_address, exp_pxl, exp_addr);
      end
      if (prev_vld) begin
        checks++;
        if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, pro_avn_readdata, pxl_avn_readdata}
            !== {prev_pxl, ~prev_pxl, prev_addr[15:0], prev_addr[15:0]}) begin
          errors++;
          $display("FAIL prio_route c=%0d: got pxl_rdv=%b pro_rdv=%b data=%h required pxl_rdv=%b data=%h",
            c, pxl_avn_readdatavalid, pro_avn_readdatavalid, pro_avn_readdata, prev_pxl, prev_addr[15:0]);
        end
      end
      prev_vld = 1; prev_pxl = exp_pxl; prev_addr = exp_addr;
      tick();
    end
    idle();
    mem_avn_readdatavalid = 1; mem_avn_readdata = prev_addr[15:0];
    #2;
    checks++;
    if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, mem_avn_read} !== {prev_pxl, ~prev_pxl, 1'b0}) begin
      errors++;
      $display("FAIL prio_drain: got pxl_rdv=%b pro_rdv=%b rd=%b required %b %b 0",
        pxl_avn_readdatavalid, pro_avn_readdatavalid, mem_avn_read, prev_pxl, ~prev_pxl);
    end
    tick();
    idle();
    tick();
  endtask

  // pro write stalled 3 cycles; pxl arrives mid-stall and must wait for the accept.
  task automatic test_hold();
    for (int c = 0; c < 5; c++) begin
      pro_avn_write = (c < 4); pro_avn_address = 18'h10;
      pro_avn_writedata = 16'h1234; pro_avn_byteenable = 2'b10;
      pxl_avn_read = (c >= 2); pxl_avn_address = 18'h3AB;
      mem_avn_waitrequest = (c < 3);
      #2;
      if (c < 4) begin
        checks++;
        if ({mem_avn_write, mem_avn_read, mem_avn_address, mem_avn_writedata, mem_avn_byteenable,
             pro_avn_waitrequest, pxl_avn_waitrequest}
            !== {1'b1, 1'b0, 18'h10, 16'h1234, 2'b10, (c < 3) ? 1'b1 : 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL hold_pro c=%0d: got wr=%b rd=%b addr=%h data=%h be=%b pro_wait=%b pxl_wait=%b",
            c, mem_avn_write, mem_avn_read, mem_avn_address, mem_avn_writedata, mem_avn_byteenable,
            pro_avn_waitrequest, pxl_avn_waitrequest);
        end
      end else begin
        checks++;
        if ({mem_avn_read, mem_avn_write, mem_avn_address, pxl_avn_waitrequest, pro_avn_waitrequest}
            !== {1'b1, 1'b0, 18'h3AB, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL hold_pxl_next: got rd=%b wr=%b addr=%h pxl_wait=%b pro_wait=%b required 1 0 3ab 0 1",
            mem_avn_read, mem_avn_write, mem_avn_address, pxl_avn_waitrequest, pro_avn_waitrequest);
        end
      end
      tick();
    end
    idle();
    mem_avn_readdatavalid = 1; mem_avn_readdata = 16'h5A5A;
    #2;
    checks++;
    if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata} !== {1'b1, 1'b0, 16'h5A5A}) begin
      errors++;
      $display("FAIL hold_resp: got pxl_rdv=%b pro_rdv=%b data=%h required 1 0 5a5a",
        pxl_avn_readdatavalid, pro_avn_readdatavalid, pxl_avn_readdata);
    end
    tick();
    idle();
    tick();
  endtask

  // No responses: pxl fills the ID FIFO, then only writes get through.
  task automatic test_outstanding();
    for (int c = 0; c < 7; c++) begin
      pxl_avn_read = 1; pxl_avn_address = 18'h40 + 18'(c);
      pro_avn_write = (c == 5); pro_avn_address = 18'h77;
      mem_avn_readdatavalid = (c == 6); mem_avn_readdata = 16'h0040;
      #2;
      checks++;
      if (c < 4) begin
        if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest} !== 3'b100) begin
          errors++;
          $display("FAIL outst_accept c=%0d: got rd=%b wr=%b pxl_wait=%b required 1 0 0",
            c, mem_avn_read, mem_avn_write, pxl_avn_waitrequest);
        end
      end else if (c == 5) begin
        if ({mem_avn_read, mem_avn_write, mem_avn_address, pro_avn_waitrequest, pxl_avn_waitrequest}
            !== {1'b0, 1'b1, 18'h77, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL outst_pro_write: got rd=%b wr=%b addr=%h pro_wait=%b pxl_wait=%b required 0 1 77 0 1",
            mem_avn_read, mem_avn_write, mem_avn_address, pro_avn_waitrequest, pxl_avn_waitrequest);
        end
      end else if (c == 6) begin
        if ({mem_avn_read, pxl_avn_waitrequest, pxl_avn_readdatavalid} !== 3'b011) begin
          errors++;
          $display("FAIL outst_full_pop: got rd=%b pxl_wait=%b pxl_rdv=%b required 0 1 1",
            mem_avn_read, pxl_avn_waitrequest, pxl_avn_readdatavalid);
        end
      end else begin
        if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest} !== 3'b001) begin
          errors++;
          $display("FAIL outst_full c=%0d: got rd=%b wr=%b pxl_wait=%b required 0 0 1",
            c, mem_avn_read, mem_avn_write, pxl_avn_waitrequest);
        end
      end
      tick();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      mem_avn_readdatavalid = 1;
      #2;
      checks++;
      if ({pxl_avn_readdatavalid, pro_avn_readdatavalid} !== 2'b10) begin
        errors++;
        $display("FAIL outst_drain c=%0d: got pxl_rdv=%b pro_rdv=%b required 1 0",
          c, pxl_avn_readdatavalid, pro_avn_readdatavalid);
      end
      tick();
    end
    idle();
    #2;
    checks++;
    if (err_rdv_unexp !== 1'b0) begin
      errors++;
      $display("FAIL outst_no_err: got %b required 0", err_rdv_unexp);
    end
    tick();
  endtask

  // pro alone, alternating write/read at 0..7; read data comes back next cycle.
  task automatic test_pro_only();
    logic       prev_rd = 0;
    logic [2:0] prev_a = '0;
    for (int c = 0; c < 9; c++) begin
      pro_avn_write = (c < 8) && (c % 2 == 0);
      pro_avn_read  = (c < 8) && (c % 2 == 1);
      pro_avn_address = 18'(c); pro_avn_writedata = 16'hB000 + 16'(c);
      mem_avn_readdatavalid = prev_rd; mem_avn_readdata = 16'hA000 + 16'(prev_a);
      #2;
      if (c < 8) begin
        checks++;
        if ({mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest,
             mem_avn_address, mem_avn_writedata}
            !== {(c % 2 == 1), (c % 2 == 0), 1'b0, 1'b1, 18'(c), 16'hB000 + 16'(c)}) begin
          errors++;
          $display("FAIL pro_only_cmd c=%0d: got rd=%b wr=%b pro_wait=%b pxl_wait=%b addr=%h data=%h",
            c, mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest,
            mem_avn_address, mem_avn_writedata);
        end
      end
      checks++;
      if ({pro_avn_readdatavalid, pxl_avn_readdatavalid, pro_avn_readdata}
          !== {prev_rd, 1'b0, 16'hA000 + 16'(prev_a)}) begin
        errors++;
        $display("FAIL pro_only_resp c=%0d: got pro_rdv=%b pxl_rdv=%b data=%h required %b 0 %h",
          c, pro_avn_readdatavalid, pxl_avn_readdatavalid, pro_avn_readdata,
          prev_rd, 16'hA000 + 16'(prev_a));
      end
      prev_rd = (c < 8) && (c % 2 == 1); prev_a = 3'(c);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_unexp_rdv();
    mem_avn_readdatavalid = 1; mem_avn_readdata = 16'hDEAD;
    #2;
    checks++;
    if ({pro_avn_readdatavalid, pxl_avn_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL unexp_drop: got pro_rdv=%b pxl_rdv=%b required 0 0",
        pro_avn_readdatavalid, pxl_avn_readdatavalid);
    end
    tick();
    mem_avn_readdatavalid = 0;
    for (int c = 0; c < 3; c++) begin
      pro_avn_write = (c == 1);
      #2;
      checks++;
      if (err_rdv_unexp !== 1'b1) begin
        errors++;
        $display("FAIL unexp_sticky c=%0d: got %b required 1", c, err_rdv_unexp);
      end
      tick();
    end
    idle();
  endtask

  // Three reads in flight and a stalled pro write, then reset mid-cycle.
  task automatic test_reset_midstall();
    for (int c = 0; c < 3; c++) begin
      pxl_avn_read = 1; pxl_avn_address = 18'h300 + 18'(c);
      tick();
    end
    idle();
    pro_avn_write = 1; pro_avn_address = 18'h55; mem_avn_waitrequest = 1;
    #2;
    checks++;
    if ({mem_avn_write, pro_avn_waitrequest, err_rdv_unexp} !== 3'b111) begin
      errors++;
      $display("FAIL midstall_pre: got wr=%b pro_wait=%b err=%b required 1 1 1",
        mem_avn_write, pro_avn_waitrequest, err_rdv_unexp);
    end
    #1 sys_rst = 1;
    #1;
    checks++;
    if ({mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest, err_rdv_unexp}
        !== 5'b00110) begin
      errors++;
      $display("FAIL midstall_async: got rd=%b wr=%b pro_wait=%b pxl_wait=%b err=%b required 0 0 1 1 0",
        mem_avn_read, mem_avn_write, pro_avn_waitrequest, pxl_avn_waitrequest, err_rdv_unexp);
    end
    tick();
    idle();
    tick();
    sys_rst = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      pxl_avn_read = 1; pxl_avn_address = 18'h380 + 18'(c);
      #2;
      checks++;
      if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest}
          !== {(c < 4), 1'b0, (c >= 4), 1'b1}) begin
        errors++;
        $display("FAIL post_reset c=%0d: got rd=%b wr=%b pxl_wait=%b pro_wait=%b required %b 0 %b 1",
          c, mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest, (c < 4), (c >= 4));
      end
      tick();
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      mem_avn_readdatavalid = 1;
      #2;
      checks++;
      if ({pxl_avn_readdatavalid, pro_avn_readdatavalid, err_rdv_unexp} !== 3'b100) begin
        errors++;
        $display("FAIL post_reset_resp c=%0d: got pxl_rdv=%b pro_rdv=%b err=%b required 1 0 0",
          c, pxl_avn_readdatavalid, pro_avn_readdatavalid, err_rdv_unexp);
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_prio_starve();
    test_hold();
    test_outstanding();
    test_pro_only();
    test_unexp_rdv();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
